// File: rtl/terminal_pkg.sv
// Shared constants, state encoding and byte classification for the terminal writer.
// TERMINAL_FORM_FEED_EN adds the CLEAR state used by the form-feed screen sweep.
package terminal_pkg;

    localparam int unsigned DEFAULT_COLS = 80;
    localparam int unsigned DEFAULT_ROWS = 30;
    localparam int unsigned ADDR_W       = 12;
    localparam int unsigned BYTE_W       = 8;

    localparam logic [BYTE_W-1:0] CH_BS    = 8'h08;
    localparam logic [BYTE_W-1:0] CH_LF    = 8'h0A;
    localparam logic [BYTE_W-1:0] CH_FF    = 8'h0C;
    localparam logic [BYTE_W-1:0] CH_CR    = 8'h0D;
    localparam logic [BYTE_W-1:0] CH_SPACE = 8'h20;
    localparam logic [BYTE_W-1:0] CH_DEL   = 8'h7F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1
`ifdef TERMINAL_FORM_FEED_EN
        ,
        ST_CLEAR = 2'd2
`endif
    } state_t;

    // Everything from SPACE upward except DEL lands in the text buffer.
    function automatic logic is_printable(logic [BYTE_W-1:0] b);
        return (b >= CH_SPACE) && (b != CH_DEL);
    endfunction

endpackage

// File: rtl/terminal_writer_if.sv
// Byte-stream handshake and text-buffer RAM write port of the terminal writer.
interface terminal_writer_if;
    import terminal_pkg::*;

    logic [BYTE_W-1:0] i_Byte;
    logic              i_Byte_Valid;
    logic              o_Byte_Ready;
    logic              o_Wr_En;
    logic [ADDR_W-1:0] o_Wr_Addr;
    logic [BYTE_W-1:0] o_Wr_Data;

    modport master (
        output i_Byte, i_Byte_Valid,
        input  o_Byte_Ready, o_Wr_En, o_Wr_Addr, o_Wr_Data
    );

    modport slave (
        input  i_Byte, i_Byte_Valid,
        output o_Byte_Ready, o_Wr_En, o_Wr_Addr, o_Wr_Data
    );

endinterface

// File: rtl/terminal_cursor_ctr.sv
// Cursor position as col/row counters plus a flat cell index kept in step incrementally.
module terminal_cursor_ctr
    import terminal_pkg::*;
#(
    parameter int unsigned COLS = DEFAULT_COLS,
    parameter int unsigned ROWS = DEFAULT_ROWS,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic              i_Clk,
    input  logic              i_Reset_L,
    input  logic              advance,
    input  logic              retreat,
    input  logic              newline,
    input  logic              down,
    input  logic              home,
    output logic [COL_W-1:0]  col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] index
);

    localparam int unsigned CELLS = COLS * ROWS;

    logic [COL_W-1:0]  col_d;
    logic [ROW_W-1:0]  row_d;
    logic [ADDR_W-1:0] index_d;
    logic              last_col;
    logic              last_row;

    assign last_col = (col == COL_W'(COLS - 1));
    assign last_row = (row == ROW_W'(ROWS - 1));

    // Index moves by +-1 or +-COLS alongside col/row, so no multiply is needed.
    always_comb begin
        col_d   = col;
        row_d   = row;
        index_d = index;
        if (home) begin
            col_d   = '0;
            row_d   = '0;
            index_d = '0;
        end else if (retreat) begin
            if (col != '0) begin
                col_d   = col - COL_W'(1);
                index_d = index - ADDR_W'(1);
            end else begin
                col_d = COL_W'(COLS - 1);
                if (row != '0) begin
                    row_d   = row - ROW_W'(1);
                    index_d = index - ADDR_W'(1);
                end else begin
                    row_d   = ROW_W'(ROWS - 1);
                    index_d = ADDR_W'(CELLS - 1);
                end
            end
        end else if (advance) begin
            if (!last_col) begin
                col_d   = col + COL_W'(1);
                index_d = index + ADDR_W'(1);
            end else begin
                col_d = '0;
                if (!last_row) begin
                    row_d   = row + ROW_W'(1);
                    index_d = index + ADDR_W'(1);
                end else begin
                    row_d   = '0;
                    index_d = '0;
                end
            end
        end else if (newline) begin
            col_d = '0;
            if (!last_row) begin
                row_d   = row + ROW_W'(1);
                index_d = index - ADDR_W'(col) + ADDR_W'(COLS);
            end else begin
                row_d   = '0;
                index_d = '0;
            end
        end else if (down) begin
            if (!last_row) begin
                row_d   = row + ROW_W'(1);
                index_d = index + ADDR_W'(COLS);
            end else begin
                row_d   = '0;
                index_d = ADDR_W'(col);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_L) begin
            col   <= '0;
            row   <= '0;
            index <= '0;
        end else begin
            col   <= col_d;
            row   <= row_d;
            index <= index_d;
        end
    end

endmodule

// File: rtl/terminal_writer.sv
// Terminal writer: turns a received byte stream and cursor buttons into text-buffer writes.
// Defining TERMINAL_FORM_FEED_EN makes 0x0C sweep the whole screen with spaces.
module terminal_writer
    import terminal_pkg::*;
#(
    parameter int unsigned COLS = DEFAULT_COLS,
    parameter int unsigned ROWS = DEFAULT_ROWS
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset_L,
    terminal_writer_if.slave        term_bus,
    input  logic                    i_Cursor_Home,
    input  logic                    i_Cursor_Left,
    input  logic                    i_Cursor_Right,
    input  logic                    i_Cursor_Down,
    output logic [ADDR_W-1:0]       o_Cursor,
    output logic                    o_Busy
);

    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef TERMINAL_FORM_FEED_EN
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);
`endif

    state_t            state_q;
    state_t            state_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [BYTE_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q;
    logic              ready_c;
    logic              xfer_c;
    logic              cur_adv, cur_ret, cur_nl, cur_down, cur_home;
    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [ADDR_W-1:0] cur_index;
    logic              unused_pos;

    assign ready_c = (state_q == ST_IDLE) && i_Reset_L;
    assign xfer_c  = term_bus.i_Byte_Valid && ready_c;

    // Col/row are kept for observability; only the flat index drives the outputs.
    assign unused_pos = ^{cur_col, cur_row};

    terminal_cursor_ctr #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .i_Clk     (i_Clk),
        .i_Reset_L (i_Reset_L),
        .advance   (cur_adv),
        .retreat   (cur_ret),
        .newline   (cur_nl),
        .down      (cur_down),
        .home      (cur_home),
        .col       (cur_col),
        .row       (cur_row),
        .index     (cur_index)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_L) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    // Buttons only act in IDLE on a cycle without a byte transfer.
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cur_adv   = 1'b0;
        cur_ret   = 1'b0;
        cur_nl    = 1'b0;
        cur_down  = 1'b0;
        cur_home  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer_c) begin
                    if (is_printable(term_bus.i_Byte)) begin
                        state_d   = ST_WRITE;
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_index;
                        wr_data_d = term_bus.i_Byte;
                    end else begin
                        case (term_bus.i_Byte)
                            CH_BS: cur_ret = 1'b1;
                            CH_CR: cur_nl  = 1'b1;
`ifdef TERMINAL_FORM_FEED_EN
                            CH_FF: begin
                                state_d   = ST_CLEAR;
                                wr_en_d   = 1'b1;
                                wr_addr_d = '0;
                                wr_data_d = CH_SPACE;
                            end
`endif
                            CH_LF, CH_DEL: ;
                            default: ;
                        endcase
                    end
                end else if (i_Cursor_Home) begin
                    cur_home = 1'b1;
                end else if (i_Cursor_Left) begin
                    cur_ret = 1'b1;
                end else if (i_Cursor_Right) begin
                    cur_adv = 1'b1;
                end else if (i_Cursor_Down) begin
                    cur_down = 1'b1;
                end
            end
            ST_WRITE: begin
                cur_adv = 1'b1;
                state_d = ST_IDLE;
            end
`ifdef TERMINAL_FORM_FEED_EN
            // The write address register doubles as the sweep position.
            ST_CLEAR: begin
                if (wr_addr_q == LAST_CELL) begin
                    state_d  = ST_IDLE;
                    cur_home = 1'b1;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign term_bus.o_Byte_Ready = ready_c;
    assign term_bus.o_Wr_En      = wr_en_q;
    assign term_bus.o_Wr_Addr    = wr_addr_q;
    assign term_bus.o_Wr_Data    = wr_data_q;
    assign o_Cursor              = cur_index;
    assign o_Busy                = busy_q;

endmodule

// File: tb/tb_terminal_writer.sv
// Self-checking bench for terminal_writer: vector table, hand sequences, random ops vs a cell-index model.
module tb_terminal_writer;
    import terminal_pkg::*;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        btn_home = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
    logic [11:0] cursor;
    logic        busy;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    terminal_writer_if bus();

    terminal_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .i_Clk          (clk),
        .i_Reset_L      (rst_l),
        .term_bus       (bus),
        .i_Cursor_Home  (btn_home),
        .i_Cursor_Left  (btn_left),
        .i_Cursor_Right (btn_right),
        .i_Cursor_Down  (btn_down),
        .o_Cursor       (cursor),
        .o_Busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int a; int d; } wr_t;
    wr_t wq[$];
    always @(negedge clk) if (bus.o_Wr_En === 1'b1) wq.push_back('{a: int'(bus.o_Wr_Addr), d: int'(bus.o_Wr_Data)});

    typedef struct {
        bit         v;
        logic [7:0] b;
        logic [3:0] btn;   // {home, left, right, down}
        int         start;
        int         exp_cur;
        bit         exp_w;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Present inputs for one cycle starting at a negedge; ends on the next negedge.
    task automatic apply(input logic [7:0] b, input bit v, input logic [3:0] btn);
        bit rd;
        bus.i_Byte = b;
        bus.i_Byte_Valid = v;
        {btn_home, btn_left, btn_right, btn_down} = btn;
        rd = bus.o_Byte_Ready;
        @(negedge clk);
        bus.i_Byte_Valid = 1'b0;
        {btn_home, btn_left, btn_right, btn_down} = 4'b0000;
        if (v) begin
            total++;
            if (!rd) begin
                bad++;
                $display("FAIL accept: byte %02h saw ready=%0b, want 1", b, rd);
            end
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic goto_cell(input int idx);
        apply(8'h00, 1'b0, 4'b1000);
        for (int r = 0; r < idx / COLS; r++) apply(8'h00, 1'b0, 4'b0001);
        for (int c = 0; c < idx % COLS; c++) apply(8'h00, 1'b0, 4'b0010);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, " wr_en"},   int'(bus.o_Wr_En), 0);
        chk({nm, " wr_addr"}, int'(bus.o_Wr_Addr), 0);
        chk({nm, " wr_data"}, int'(bus.o_Wr_Data), 0);
        chk({nm, " cursor"},  int'(cursor), 0);
        chk({nm, " busy"},    int'(busy), 0);
        chk({nm, " ready"},   int'(bus.o_Byte_Ready), 0);
    endtask

    task automatic check_op(input string nm, input int exp_cur, input bit exp_w,
                            input int exp_addr, input int exp_data);
        chk({nm, " cursor"}, int'(cursor), exp_cur);
        chk({nm, " writes"}, wq.size(), exp_w ? 1 : 0);
        if (exp_w && wq.size() == 1) begin
            chk({nm, " addr"}, wq[0].a, exp_addr);
            chk({nm, " data"}, wq[0].d, exp_data);
        end
    endtask

    function automatic int m_adv(input int c);  return (c + 1) % CELLS;         endfunction
    function automatic int m_ret(input int c);  return (c + CELLS - 1) % CELLS; endfunction
    function automatic int m_nl(input int c);   return ((c / COLS + 1) % ROWS) * COLS; endfunction
    function automatic int m_down(input int c); return ((c / COLS + 1) % ROWS) * COLS + c % COLS; endfunction

    task automatic model_op(input int c, input logic [7:0] b, input bit v, input logic [3:0] btn,
                            output int nc, output bit w);
        nc = c;
        w  = 1'b0;
        if (v) begin
            if (b >= 8'h20 && b != 8'h7F) begin w = 1'b1; nc = m_adv(c); end
            else if (b == 8'h08) nc = m_ret(c);
            else if (b == 8'h0D) nc = m_nl(c);
        end else if (btn[3]) nc = 0;
        else if (btn[2]) nc = m_ret(c);
        else if (btn[1]) nc = m_adv(c);
        else if (btn[0]) nc = m_down(c);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before completion, want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ctl [7];
        logic [7:0] str [5];
        int         acc [5];
        int         m_cur, nc, i, t, n, errs;
        bit         w, v, rd;
        logic [7:0] b;
        logic [3:0] btn;

        bus.i_Byte = 8'h00;
        bus.i_Byte_Valid = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_l = 1'b1;
        @(negedge clk);
        chk("ready after reset", int'(bus.o_Byte_Ready), 1);

        // 'A' then 'B' from reset, write strobe one cycle wide
        wq.delete();
        apply(8'h41, 1'b1, 4'b0000);
        chk("A wr_en", int'(bus.o_Wr_En), 1);
        chk("A addr", int'(bus.o_Wr_Addr), 0);
        chk("A data", int'(bus.o_Wr_Data), 8'h41);
        chk("A busy", int'(busy), 1);
        chk("A ready in WRITE", int'(bus.o_Byte_Ready), 0);
        @(negedge clk);
        chk("A wr_en drops", int'(bus.o_Wr_En), 0);
        chk("A cursor", int'(cursor), 1);
        apply(8'h42, 1'b1, 4'b0000);
        chk("B addr", int'(bus.o_Wr_Addr), 1);
        chk("B data", int'(bus.o_Wr_Data), 8'h42);
        @(negedge clk);
        chk("B wr_en drops", int'(bus.o_Wr_En), 0);
        settle();
        chk("AB cursor", int'(cursor), 2);
        chk("AB writes", wq.size(), 2);

        // Vector table
        vt.push_back('{1'b1, 8'h41, 4'b0000,    0,    1, 1'b1});
        vt.push_back('{1'b1, 8'h5A, 4'b0000, 2399,    0, 1'b1});
        vt.push_back('{1'b1, 8'h08, 4'b0000,    0, 2399, 1'b0});
        vt.push_back('{1'b1, 8'h08, 4'b0000,   81,   80, 1'b0});
        vt.push_back('{1'b1, 8'h0D, 4'b0000,   85,  160, 1'b0});
        vt.push_back('{1'b1, 8'h0D, 4'b0000, 2350,    0, 1'b0});
        vt.push_back('{1'b1, 8'h0A, 4'b0000,  123,  123, 1'b0});
        vt.push_back('{1'b1, 8'h7F, 4'b0000,  123,  123, 1'b0});
        vt.push_back('{1'b1, 8'h1B, 4'b0000,    7,    7, 1'b0});
        vt.push_back('{1'b1, 8'h80, 4'b0000,   79,   80, 1'b1});
        vt.push_back('{1'b1, 8'hFF, 4'b0000, 2319, 2320, 1'b1});
        vt.push_back('{1'b1, 8'h20, 4'b0000,    5,    6, 1'b1});
        vt.push_back('{1'b1, 8'h7E, 4'b0000,    6,    7, 1'b1});
        vt.push_back('{1'b0, 8'h00, 4'b1000,   85,    0, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0100,    0, 2399, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0100,   80,   79, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0010, 2399,    0, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0010,   79,   80, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0001,   85,  165, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0001, 2330,   10, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0110,   85,   84, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0011,   85,   86, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b1111,   85,    0, 1'b0});
        vt.push_back('{1'b0, 8'h00, 4'b0101,   85,   84, 1'b0});
`ifndef TERMINAL_FORM_FEED_EN
        vt.push_back('{1'b1, 8'h0C, 4'b0000,  500,  500, 1'b0});
`endif
        foreach (vt[k]) begin
            goto_cell(vt[k].start);
            wq.delete();
            apply(vt[k].b, vt[k].v, vt[k].btn);
            settle();
            check_op($sformatf("vec%0d", k), vt[k].exp_cur, vt[k].exp_w, vt[k].start, int'(vt[k].b));
        end

        // Right pulse with a byte transfer and during WRITE is dropped
        goto_cell(10);
        wq.delete();
        apply(8'h78, 1'b1, 4'b0010);
        apply(8'h00, 1'b0, 4'b0010);
        settle();
        check_op("byte+right", 11, 1'b1, 10, 8'h78);

        // Valid held high across five bytes: one transfer every two cycles
        str = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        goto_cell(200);
        wq.delete();
        i = 0;
        t = 0;
        while (i < 5 && t < 40) begin
            bus.i_Byte = str[i];
            bus.i_Byte_Valid = 1'b1;
            rd = bus.o_Byte_Ready;
            if (rd) acc[i] = cyc;
            @(negedge clk);
            t++;
            if (rd) i++;
        end
        bus.i_Byte_Valid = 1'b0;
        settle();
        chk("stream accepted", i, 5);
        chk("stream writes", wq.size(), 5);
        chk("stream cursor", int'(cursor), 205);
        if (i == 5 && wq.size() == 5) begin
            errs = 0;
            for (int k = 0; k < 5; k++) begin
                if (wq[k].a != 200 + k || wq[k].d != int'(str[k])) errs++;
                if (k > 0 && acc[k] - acc[k-1] != 2) errs++;
            end
            chk("stream order/spacing errors", errs, 0);
        end

        // Reset during WRITE
        goto_cell(30);
        wq.delete();
        apply(8'h51, 1'b1, 4'b0000);
        rst_l = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset in WRITE");
        rst_l = 1'b1;
        settle();
        chk("reset in WRITE writes", wq.size(), 1);
        chk("reset in WRITE cursor", int'(cursor), 0);

`ifdef TERMINAL_FORM_FEED_EN
        // Form feed sweep
        goto_cell(500);
        wq.delete();
        apply(8'h0C, 1'b1, 4'b0000);
        n = 0;
        errs = 0;
        while (busy && n < 3000) begin
            if (bus.o_Byte_Ready) errs++;
            @(negedge clk);
            n++;
        end
        chk("clear finished", int'(busy), 0);
        chk("clear ready low cycles", errs, 0);
        chk("clear writes", wq.size(), CELLS);
        errs = 0;
        foreach (wq[k]) if (wq[k].a != k || wq[k].d != 32) errs++;
        chk("clear contents errors", errs, 0);
        chk("clear cursor", int'(cursor), 0);

        // Reset in the middle of the sweep
        goto_cell(500);
        apply(8'h0C, 1'b1, 4'b0000);
        n = 0;
        while (!(bus.o_Wr_En && bus.o_Wr_Addr == 12'd1000) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("sweep reached 1000", int'(bus.o_Wr_Addr), 1000);
        rst_l = 1'b0;
        @(negedge clk);
        wq.delete();
        check_reset_outputs("reset in CLEAR");
        @(negedge clk);
        rst_l = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset in CLEAR writes", wq.size(), 0);
        chk("reset in CLEAR busy", int'(busy), 0);
        chk("reset in CLEAR cursor", int'(cursor), 0);
`endif

        // Random ops against the cell-index model
        ctl = '{8'h08, 8'h0D, 8'h0A, 8'h7F, 8'h00, 8'h1B, 8'h09};
        apply(8'h00, 1'b0, 4'b1000);
        settle();
        m_cur = 0;
        for (int k = 0; k < 200; k++) begin
            n = $urandom_range(0, 9);
            btn = 4'b0000;
            if (n <= 3) begin
                v = 1'b1;
                b = 8'($urandom_range(32, 255));
                if (b == 8'h7F) b = 8'h41;
            end else if (n <= 5) begin
                v = 1'b1;
                b = ctl[$urandom_range(0, 6)];
            end else begin
                v = 1'b0;
                b = 8'($urandom_range(0, 255));
                btn = 4'($urandom_range(1, 15));
            end
            if (v && $urandom_range(0, 3) == 0) btn = 4'($urandom_range(1, 15));
            model_op(m_cur, b, v, btn, nc, w);
            wq.delete();
            apply(b, v, btn);
            settle();
            check_op($sformatf("rand%0d", k), nc, w, m_cur, int'(b));
            m_cur = nc;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/terminal_writer.md
TERMINAL_WRITER -- requirements
Module: terminal_writer

Interface
REQ-001 Parameter COLS, default 80: text columns per row.
REQ-002 Parameter ROWS, default 30: text rows per screen.
REQ-003 i_Clk  input  1  sole clock; all logic on its rising edge.
REQ-004 i_Reset_L  input  1  synchronous, active-low reset.
REQ-005 i_Byte  input  8  received character from the UART receive stage.
REQ-006 i_Byte_Valid  input  1  i_Byte holds a valid character.
REQ-007 o_Byte_Ready  output  1  block can accept a byte; a transfer occurs on any cycle where i_Byte_Valid and o_Byte_Ready are both 1.
REQ-008 i_Cursor_Home, i_Cursor_Left, i_Cursor_Right, i_Cursor_Down  input  1 each  single-cycle debounced button pulses.
REQ-009 o_Wr_En  output  1  text-buffer RAM write strobe.
REQ-010 o_Wr_Addr  output  12  RAM cell index, 0..COLS*ROWS-1.
REQ-011 o_Wr_Data  output  8  character code to write.
REQ-012 o_Cursor  output  12  current cursor cell index, row*COLS+col, registered.
REQ-013 o_Busy  output  1  block is in any state other than IDLE.

Function
REQ-014 The block shall track the cursor as separate col (0..COLS-1) and row (0..ROWS-1) counters, and shall derive o_Cursor from them; no divide or modulo is used.
REQ-015 States shall be IDLE, WRITE and CLEAR; o_Byte_Ready = 1 only in IDLE with i_Reset_L = 1.
REQ-016 Printable byte (0x20..0x7E, or >= 0x80) accepted in IDLE: next cycle is WRITE, with o_Wr_En = 1 for exactly one cycle, o_Wr_Addr = old cursor, o_Wr_Data = byte.
REQ-017 In the WRITE cycle the cursor shall advance col+1; at col = COLS-1, col goes to 0 and row+1; at the last cell it wraps to cell 0. The state then returns to IDLE, so peak throughput is one byte per 2 cycles.
REQ-018 0x08 (backspace) shall be consumed with no write, and shall move the cursor back one cell; from cell 0 it wraps to cell COLS*ROWS-1. This takes effect on the cycle after acceptance, and the state stays in IDLE.
REQ-019 0x0D (carriage return) shall be consumed with no write, and shall set col = 0 and row+1; from row ROWS-1 it goes to row 0.
REQ-020 0x0A, 0x7F and all other codes below 0x20 not given a meaning elsewhere shall be consumed with no write and no cursor change.
REQ-021 Button pulses shall be honoured only in IDLE on a cycle with no byte transfer; a pulse arriving in WRITE or CLEAR, or on a transfer cycle, shall be dropped.
REQ-022 Button priority shall be Home > Left > Right > Down.
REQ-023 Button effects: Home sets cell 0. Left behaves as REQ-018. Right behaves as the REQ-017 advance. Down sets row+1, wrapping to row 0, with col unchanged.
REQ-024 o_Wr_En shall be 0 in every cycle other than the cases required by REQ-016 and REQ-027.

Reset
REQ-025 While i_Reset_L = 0 at a clock edge, the block shall set: state IDLE, col = 0, row = 0, o_Cursor = 0, o_Wr_En = 0, o_Wr_Addr = 0, o_Wr_Data = 0, o_Busy = 0, o_Byte_Ready = 0.
REQ-026 Reset shall abort WRITE or CLEAR immediately; no further writes from the aborted operation shall be issued.

Configuration
REQ-027 With TERMINAL_FORM_FEED_EN defined, accepting 0x0C shall enter CLEAR. The block shall then issue COLS*ROWS consecutive writes of 0x20 to addresses 0, 1, ..., COLS*ROWS-1, one per cycle, and then set cursor = 0 and return to IDLE.
REQ-028 Without TERMINAL_FORM_FEED_EN, 0x0C shall be handled as in REQ-020, and no CLEAR state or sweep counter shall exist.

Structure
REQ-029 The shared package terminal_pkg shall hold default COLS and ROWS, the control-code constants (BS 0x08, LF 0x0A, FF 0x0C, CR 0x0D, SPACE 0x20, DEL 0x7F) and the state encoding.
REQ-030 The col/row wrap logic shall be one sub-module, terminal_cursor_ctr, with inputs for advance, retreat, newline, down and home, and outputs for col, row and index.

Verification
REQ-031 Reset, then send 'A' (0x41) then 'B' -> writes (0,0x41) then (1,0x42), each o_Wr_En pulse is 1 cycle, and o_Cursor = 2.
REQ-032 Cursor 2399, send 0x5A -> write at 2399, o_Cursor = 0; then send 0x08 -> o_Cursor = 2399 with no write.
REQ-033 Cursor 85, send 0x0D -> o_Cursor = 160; cursor 2350, send 0x0D -> o_Cursor = 0; send 0x0A -> no change.
REQ-034 Byte valid and i_Cursor_Right pulse in the same IDLE cycle -> byte written, Right dropped, cursor advances by 1 only.
REQ-035 With TERMINAL_FORM_FEED_EN, cursor 500, send 0x0C -> 2400 writes of 0x20 at addresses 0..2399, o_Byte_Ready = 0 throughout, then o_Cursor = 0. Repeat with i_Reset_L = 0 at sweep address 1000 -> no writes after reset, all outputs at reset values.
REQ-036 Hold i_Byte_Valid high with 5 printable bytes -> exactly 5 writes, one transfer every 2 cycles, no byte lost or duplicated.
